// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared defaults, RV64M funct3 encodings and operation-class helpers
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RD_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic is_signed_b(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_unit.sv
// muldiv_sign_unit: combinational conditional two's-complement negate.
// With neg_i = (signed && msb) it yields the magnitude of an operand;
// with neg_i = result-sign it applies the final sign fix.
module muldiv_sign_unit #(
  parameter int W = 64
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide, one op in flight, valid/ready both sides.
// Latency: accept in cycle T -> out_valid in T+XLEN+1 (T+1 for zero-operand shortcuts
// when MULDIV_EARLY_OUT_EN is defined). Result holds in DONE until out_ready.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RD_W = RD_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  // mul: {partial product hi, multiplier shifting out}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q, acc_d;
  // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  // ---------------- operand preparation ----------------
  op_e             in_op_e;
  logic            a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;

  assign in_op_e = op_e'(in_op);
  assign a_neg   = is_signed_a(in_op_e) && in_a[XLEN-1];
  assign b_neg   = is_signed_b(in_op_e) && in_b[XLEN-1];
  assign b_zero  = (in_b == '0);

  muldiv_sign_unit #(.W(XLEN)) u_abs_a (.val_i(in_a), .neg_i(a_neg), .res_o(a_mag));
  muldiv_sign_unit #(.W(XLEN)) u_abs_b (.val_i(in_b), .neg_i(b_neg), .res_o(b_mag));

  // ---------------- per-iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next, step_next;

  // One shift-add multiply step and one restoring divide step on acc_q.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){acc_q[0]}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
    step_next = is_div(op_q) ? div_next : mul_next;
  end

  // ---------------- final sign fix ----------------
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   result;

  // Pick the raw quotient/remainder/product and the sign that applies to it.
  always_comb begin
    if (is_div(op_q)) begin
      fix_in = {{XLEN{1'b0}}, (is_rem(op_q) ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0])};
    end else begin
      fix_in = step_next;
    end
    fix_neg = is_rem(op_q) ? neg_rem_q : neg_q;
  end

  // The full double-width product is negated so MULH/MULHSU high halves are exact.
  muldiv_sign_unit #(.W(2*XLEN)) u_fix (.val_i(fix_in), .neg_i(fix_neg), .res_o(fix_out));

  assign result = (is_div(op_q) || op_q == OP_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_hit;
  logic [XLEN-1:0] early_res;

  // Results that are known at accept time: x/0 and multiply by zero.
  always_comb begin
    early_hit = is_div(in_op_e) ? b_zero : ((in_a == '0) || b_zero);
    early_res = '0;
    if (is_div(in_op_e)) begin
      early_res = is_rem(in_op_e) ? in_a : '1;
    end
  end
`endif

  // Next-state logic: flush beats everything except reset; accept only in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d      = in_op_e;
            rd_d      = in_rd;
            acc_d     = {{XLEN{1'b0}}, a_mag};
            opb_d     = b_mag;
            cnt_d     = '0;
            // divide by zero returns all ones regardless of operand signs
            neg_d     = (a_neg ^ b_neg) && !(is_div(in_op_e) && b_zero);
            neg_rem_d = a_neg;
            state_d   = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state_d = S_DONE;
              res_d   = early_res;
            end
`endif
          end
        end
        S_CALC: begin
          acc_d = step_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_DONE;
            res_d   = result;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = res_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; reference results come from
// plain 128-bit / signed arithmetic, checked by an independent output monitor.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_data;
  logic [4:0]  in_rd, out_rd;

  logic rdy_man, rdy_rand, rnd_rdy, mon_on;
  assign out_ready = rdy_rand ? rnd_rdy : rdy_man;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  muldiv_unit #(.XLEN(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural RV64M result from the instruction definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0]       ea, eb, p;
    logic signed [63:0] sa, sb, sq;
    logic [63:0]        r;
    sa = a;
    sb = b;
    ea = {{64{a[63] & (op == 3'd1 || op == 3'd2)}}, a};
    eb = {{64{b[63] & (op == 3'd1)}}, b};
    p  = ea * eb;
    r  = '0;
    case (op)
      3'd0:       r = p[63:0];
      3'd1, 3'd2,
      3'd3:       r = p[127:64];
      3'd4: begin
        if (b == 0) r = ONES;
        else if (a == MINV && b == ONES) r = MINV;
        else begin sq = sa / sb; r = sq; end
      end
      3'd5:       r = (b == 0) ? ONES : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MINV && b == ONES) r = '0;
        else begin sq = sa % sb; r = sq; end
      end
      default:    r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Output monitor: latency on the rising edge of out_valid, data/tag on handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (mon_on && out_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_valid: got rd=%0d data=%h want none", out_rd, out_data);
        end else begin
          chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
        end
      end
      if (mon_on && out_valid && out_ready && sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_rd", 64'(out_rd), 64'(e.rd));
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rd, input bit push);
    exp_t e;
    int   n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else if (push) begin
      e.data = ref_model(op, a, b); e.rd = rd; e.acc = cyc; e.lat = exp_lat(op, a, b);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL wait_valid_timeout: got out_valid=0 want 1");
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = ONES;
      2:       v = MINV;
      3:       v = 64'($urandom_range(0, 20));
      4:       v = {$urandom, $urandom};
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] bp_exp;
    int          seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    rdy_man = 1'b1; rdy_rand = 1'b0; mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    @(posedge clk); #1;

    // directed vectors
    send(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 1'b1);
    send(3'd1, ONES, ONES, 5'd2, 1'b1);
    send(3'd3, ONES, ONES, 5'd3, 1'b1);
    send(3'd2, ONES, 64'd2, 5'd4, 1'b1);
    send(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 1'b1);
    send(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 1'b1);
    send(3'd5, 64'd100, 64'd7, 5'd7, 1'b1);
    send(3'd7, 64'd100, 64'd7, 5'd8, 1'b1);
    send(3'd4, 64'd5, 64'd0, 5'd9, 1'b1);
    send(3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd10, 1'b1);
    send(3'd4, MINV, ONES, 5'd11, 1'b1);
    send(3'd6, MINV, ONES, 5'd12, 1'b1);
    send(3'd0, 64'd0, 64'd12345, 5'd13, 1'b1);
    send(3'd5, ONES, 64'd0, 5'd14, 1'b1);
    drain(2000);

    // backpressure: hold DONE for 10 cycles while new requests are offered
    rdy_man = 1'b0;
    bp_exp = ref_model(3'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    send(3'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd21, 1'b1);
    wait_valid(200);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", out_data, bp_exp);
      chk("bp_out_rd", 64'(out_rd), 64'd21);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd0; in_a = {$urandom, $urandom}; in_b = 64'd3; in_rd = 5'd30;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rdy_man = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_sb_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;

    // flush while iterating (cnt == 20)
    send(3'd0, 64'd3, 64'd5, 5'd15, 1'b0);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    // flush together with a request in IDLE: nothing is accepted
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 64'd3; in_b = 64'd5; in_rd = 5'd16;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_out_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // reset while holding a result in DONE
    mon_on = 1'b0; rdy_man = 1'b0;
    send(3'd0, 64'd3, 64'd5, 5'd17, 1'b0);
    wait_valid(200);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_done_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done_out_data", out_data, 64'd0);
    chk("rst_done_out_rd", 64'(out_rd), 64'd0);
    chk("rst_done_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0; mon_on = 1'b1; rdy_man = 1'b1;
    @(posedge clk); #1;

    // back-to-back random traffic with random writeback stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1'b1);
    end
    drain(4000);
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
